// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: datapath width,
// reset-PC default and FSM state encoding.
package pc_sequencer_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_ra_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the
// oldest entry and sets a sticky overflow flag; a pop on empty does nothing.
module ra_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_value,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] top_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;
    logic [PTR_W-1:0] push_ptr;
    logic             full;

    // The pointer wraps naturally because DEPTH is a power of two, so the
    // slot after the top is the oldest entry once the stack is full.
    assign push_ptr = top_ptr_reg + PTR_W'(1);
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == DEPTH_CNT);
    assign top      = empty ? '0 : mem[top_ptr_reg];
    assign overflow = overflow_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[push_ptr] <= push_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr_reg  <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (push) begin
            top_ptr_reg <= push_ptr;
            if (full) begin
                overflow_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            top_ptr_reg <= top_ptr_reg - PTR_W'(1);
            count_reg   <= count_reg - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: issues the PC to fetch, waits for resolve, computes
// the next PC. Define PC_SEQ_RAS_EN for a RAS_DEPTH-entry return-address stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic [PC_W-1:0] pc,
    input  logic            resolve,
    input  logic            branch,
    input  logic            jump_abs,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic [PC_W-1:0] jump_value,
    output logic [PC_W-1:0] ra_value,
    output logic            ras_overflow
);

    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("RAS_DEPTH must be a power of two in 2..16");
    end

    pc_state_t       state_reg;
    pc_state_t       state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic            resolve_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ISSUE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A handshake takes precedence over halt in the same ISSUE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ISSUE: begin
                if (pc_ready) begin
                    state_next = ST_WAIT;
                end else if (halt) begin
                    state_next = ST_HALT;
                end
            end
            ST_WAIT: begin
                if (resolve) begin
                    state_next = ST_ISSUE;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    always_comb begin
        pc_valid     = (state_reg == ST_ISSUE);
        resolve_fire = (state_reg == ST_WAIT) && resolve;
    end

    assign pc_inc = pc_reg + PC_W'(1);

    always_comb begin
        pc_next = pc_reg;
        if (resolve_fire) begin
            if (is_ret) begin
                pc_next = jump_value;
            end else if (branch && jump_abs) begin
                pc_next = jump_value;
            end else if (branch) begin
                pc_next = pc_inc + jump_value;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

`ifdef PC_SEQ_RAS_EN
    // Call wins over ret for the stack when both are flagged.
    ra_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ra_stack (
        .clk        (clk),
        .rst        (rst),
        .push       (resolve_fire && is_call),
        .pop        (resolve_fire && is_ret && !is_call),
        .push_value (pc_inc),
        .top        (ra_value),
        .empty      (),
        .overflow   (ras_overflow)
    );
`else
    logic [PC_W-1:0] ra_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ra_reg <= '0;
        end else if (resolve_fire && is_call) begin
            ra_reg <= pc_inc;
        end
    end

    assign ra_value     = ra_reg;
    assign ras_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer against a queue-based
// reference model; honours PC_SEQ_RAS_EN like the design.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          RAS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        pc_valid;
    logic        pc_ready = 1'b0;
    logic [31:0] pc;
    logic        resolve = 1'b0;
    logic        branch = 1'b0;
    logic        jump_abs = 1'b0;
    logic        is_call = 1'b0;
    logic        is_ret = 1'b0;
    logic [31:0] jump_value = '0;
    logic [31:0] ra_value;
    logic        ras_overflow;

    pc_sequencer #(
        .RESET_PC  (RESET_PC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .pc           (pc),
        .resolve      (resolve),
        .branch       (branch),
        .jump_abs     (jump_abs),
        .is_call      (is_call),
        .is_ret       (is_ret),
        .jump_value   (jump_value),
        .ra_value     (ra_value),
        .ras_overflow (ras_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a fetch is outstanding or not, halted or not, and the
    // return addresses are a bounded queue (newest at the back).
    logic [31:0] pc_m     = RESET_PC;
    bit          waiting  = 1'b0;
    bit          halted   = 1'b0;
    logic [31:0] ras_q[$];
    logic [31:0] ra_m     = '0;
    bit          ovf_m    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ra_expected();
`ifdef PC_SEQ_RAS_EN
        return (ras_q.size() == 0) ? 32'h0 : ras_q[ras_q.size()-1];
`else
        return ra_m;
`endif
    endfunction

    task automatic model_update();
        logic [31:0] nxt;
        if (rst) begin
            pc_m    = RESET_PC;
            waiting = 1'b0;
            halted  = 1'b0;
            ras_q.delete();
            ra_m    = '0;
            ovf_m   = 1'b0;
        end else if (halted) begin
            // frozen until reset
        end else if (!waiting) begin
            if (pc_ready) waiting = 1'b1;
            else if (halt) halted = 1'b1;
        end else if (resolve) begin
            if (is_ret)                 nxt = jump_value;
            else if (branch && jump_abs) nxt = jump_value;
            else if (branch)            nxt = pc_m + 32'd1 + jump_value;
            else                        nxt = pc_m + 32'd1;
`ifdef PC_SEQ_RAS_EN
            if (is_call) begin
                ras_q.push_back(pc_m + 32'd1);
                if (ras_q.size() > RAS_DEPTH) begin
                    void'(ras_q.pop_front());
                    ovf_m = 1'b1;
                end
            end else if (is_ret && ras_q.size() > 0) begin
                void'(ras_q.pop_back());
            end
`else
            if (is_call) ra_m = pc_m + 32'd1;
`endif
            pc_m    = nxt;
            waiting = 1'b0;
        end
    endtask

    // One clock: DUT and model both advance, then outputs are compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("pc", pc, pc_m);
        check("pc_valid", {31'b0, pc_valid}, {31'b0, !waiting && !halted});
        check("ra_value", ra_value, ra_expected());
        check("ras_overflow", {31'b0, ras_overflow}, {31'b0, ovf_m});
    endtask

    task automatic clear_inputs();
        rst = 1'b0; halt = 1'b0; pc_ready = 1'b0; resolve = 1'b0;
        branch = 1'b0; jump_abs = 1'b0; is_call = 1'b0; is_ret = 1'b0;
        jump_value = '0;
    endtask

    // Handshake one fetch, then resolve it with the given control flags.
    task automatic instr(input logic br, input logic abs, input logic call,
                         input logic ret, input logic [31:0] jv);
        logic [31:0] from_pc;
        from_pc = pc;
        clear_inputs();
        pc_ready = 1'b1;
        tick();
        clear_inputs();
        resolve = 1'b1; branch = br; jump_abs = abs; is_call = call; is_ret = ret;
        jump_value = jv;
        tick();
        clear_inputs();
        $display("instr pc=0x%08h br=%0b abs=%0b call=%0b ret=%0b jv=0x%08h -> pc=0x%08h ra=0x%08h",
                 from_pc, br, abs, call, ret, jv, pc, ra_value);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] ret_exp [5];

    initial begin
        @(negedge clk);
        do_reset();

        // Reset state held while fetch stalls
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_pc", pc, 32'h0);
            check("reset_valid", {31'b0, pc_valid}, 32'h1);
        end
        check("reset_ra", ra_value, 32'h0);
        instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("seq_pc", pc, 32'h1);

        // Relative branches
        instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h5);
        check("br_off5", pc, 32'h16);
        instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("br_off0", pc, 32'h11);

        // Wraparound and absolute target
        instr(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap", pc, 32'h0);
        instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
        check("abs", pc, 32'h40);

        // Call then return
        instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
        instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h10);
        check("call_pc", pc, 32'h31);
        check("call_ra", ra_value, 32'h21);
        instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h21);
        check("ret_pc", pc, 32'h21);
`ifdef PC_SEQ_RAS_EN
        check("ret_ra", ra_value, 32'h0);

        // Five nested calls into a four-deep stack drop the oldest (0x01)
        for (int i = 0; i < 5; i++) begin
            instr(1'b1, 1'b1, 1'b0, 1'b0, 32'(i * 16));
            instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        check("ras_ovf", {31'b0, ras_overflow}, 32'h1);
        ret_exp[0] = 32'h31; ret_exp[1] = 32'h21; ret_exp[2] = 32'h11;
        ret_exp[3] = 32'h0;  ret_exp[4] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
            check("ras_pop", ra_value, ret_exp[i]);
        end
`else
        check("ret_ra", ra_value, 32'h21);
`endif

        // Reset arriving together with resolve in WAIT
        instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
        clear_inputs();
        pc_ready = 1'b1;
        tick();
        clear_inputs();
        rst = 1'b1; resolve = 1'b1; branch = 1'b1; is_call = 1'b1; jump_value = 32'h7;
        tick();
        clear_inputs();
        check("rst_wait_pc", pc, RESET_PC);
        check("rst_wait_valid", {31'b0, pc_valid}, 32'h1);
        check("rst_wait_ra", ra_value, 32'h0);

        // Halt in ISSUE sticks until reset
        halt = 1'b1;
        tick();
        check("halt_valid", {31'b0, pc_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            halt = 1'b0; pc_ready = i[0]; resolve = !i[0]; jump_value = 32'h55;
            tick();
            check("halt_hold", {31'b0, pc_valid}, 32'h0);
        end
        do_reset();
        tick();
        check("halt_exit", {31'b0, pc_valid}, 32'h1);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            halt       = ($urandom_range(0, 199) == 0);
            pc_ready   = $urandom_range(0, 1) == 1;
            resolve    = !pc_ready && ($urandom_range(0, 1) == 1);
            branch     = $urandom_range(0, 1) == 1;
            jump_abs   = ($urandom_range(0, 3) == 0);
            is_call    = ($urandom_range(0, 4) == 0);
            is_ret     = ($urandom_range(0, 4) == 0);
            jump_value = ($urandom_range(0, 2) == 0) ? $urandom() : 32'($urandom_range(0, 63));
            tick();
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
